// File: rtl/saturate_pkg.sv
// saturate_pkg: default widths, counter width and clamp-limit helpers for saturate_u8
package saturate_pkg;
  localparam int IN_W_DEF  = 10;
  localparam int OUT_W_DEF = 8;
  localparam int CNT_W     = 16;
  function automatic longint max_lim(input int w, input bit s);
    return s ? (longint'(1) <<< (w - 1)) - longint'(1) : (longint'(1) <<< w) - longint'(1);
  endfunction
  function automatic longint min_lim(input int w, input bit s);
    return s ? -(longint'(1) <<< (w - 1)) : longint'(0);
  endfunction
endpackage

// File: rtl/sat_core.sv
// sat_core: combinational clamp of an IN_W-bit word into OUT_W bits, unsigned or two's-complement
module sat_core
  import saturate_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SIGNED = 0
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] result,
  output logic             hi,
  output logic             lo
);
  localparam longint MAX = max_lim(OUT_W, SIGNED != 0);
  localparam longint MIN = min_lim(OUT_W, SIGNED != 0);
  logic signed [63:0] x;
  // widen din to 64 bits so both limits compare exactly in one signed domain
  always_comb begin
    x      = SIGNED != 0 ? 64'($signed(din)) : $signed(64'(din));
    hi     = x > MAX;
    lo     = x < MIN;
    result = hi ? MAX[OUT_W-1:0] : lo ? MIN[OUT_W-1:0] : din[OUT_W-1:0];
  end
endmodule

// File: rtl/saturate_u8.sv
// saturate_u8: registered saturating narrower with optional saturation counter (SATURATE_U8_STATS_EN)
module saturate_u8
  import saturate_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  din,
  input  logic             cnt_clr,
  output logic [OUT_W-1:0] dout,
  output logic             out_valid,
  output logic             sat_hi,
  output logic             sat_lo,
  output logic [CNT_W-1:0] sat_count
);
  logic [OUT_W-1:0] res, dout_q, dout_d;
  logic             hi, lo, vld_q, hi_q, lo_q, hi_d, lo_d;
  sat_core #(.IN_W(IN_W), .OUT_W(OUT_W), .SIGNED(SIGNED)) u_core (
    .din(din), .result(res), .hi(hi), .lo(lo)
  );
  // dout holds across idle cycles; flags only describe a freshly registered sample
  always_comb begin
    dout_d = in_valid ? res : dout_q;
    hi_d   = in_valid & hi;
    lo_d   = in_valid & lo;
  end
  // single output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      hi_q   <= 1'b0;
      lo_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= in_valid;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end
  assign dout      = dout_q;
  assign out_valid = vld_q;
  assign sat_hi    = hi_q;
  assign sat_lo    = lo_q;
`ifdef SATURATE_U8_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // clear wins over increment; the count sticks at all ones
  always_comb cnt_d = cnt_clr ? '0 : (in_valid && (hi || lo) && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  // saturation event counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign sat_count = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = cnt_clr;
  assign sat_count  = '0;
`endif
endmodule

// File: tb/tb_saturate_u8.sv
// tb_saturate_u8: directed + random checks of unsigned and signed saturate_u8 against an arithmetic model
module tb_saturate_u8;
  localparam bit STATS =
`ifdef SATURATE_U8_STATS_EN
    1'b1;
`else
    1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cnt_clr = 1'b0;
  logic [9:0]  din = '0;
  logic [7:0]  u_dout, s_dout;
  logic        u_ov, u_hi, u_lo, s_ov, s_hi, s_lo;
  logic [15:0] u_cnt, s_cnt;
  int          total = 0, bad = 0;
  logic [7:0]  eu_d, es_d;
  logic        ev, euh, esh, esl;
  int          eu_c, es_c;
  always #5 clk = ~clk;
  saturate_u8 u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din(din), .cnt_clr(cnt_clr),
    .dout(u_dout), .out_valid(u_ov), .sat_hi(u_hi), .sat_lo(u_lo), .sat_count(u_cnt)
  );
  saturate_u8 #(.SIGNED(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din(din), .cnt_clr(cnt_clr),
    .dout(s_dout), .out_valid(s_ov), .sat_hi(s_hi), .sat_lo(s_lo), .sat_count(s_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, " u.dout"}, 32'(u_dout), 32'(eu_d));
    chk({tag, " u.out_valid"}, 32'(u_ov), 32'(ev));
    chk({tag, " u.sat_hi"}, 32'(u_hi), 32'(euh));
    chk({tag, " u.sat_lo"}, 32'(u_lo), 32'(0));
    chk({tag, " u.sat_count"}, 32'(u_cnt), 32'(eu_c));
    chk({tag, " s.dout"}, 32'(s_dout), 32'(es_d));
    chk({tag, " s.out_valid"}, 32'(s_ov), 32'(ev));
    chk({tag, " s.sat_hi"}, 32'(s_hi), 32'(esh));
    chk({tag, " s.sat_lo"}, 32'(s_lo), 32'(esl));
    chk({tag, " s.sat_count"}, 32'(s_cnt), 32'(es_c));
  endtask
  task automatic model_reset();
    eu_d = '0; es_d = '0; ev = 0; euh = 0; esh = 0; esl = 0; eu_c = 0; es_c = 0;
  endtask
  task automatic step(input string tag, input logic v, input logic [9:0] d, input logic c, input bit ck);
    int ui, si;
    in_valid = v; din = d; cnt_clr = c;
    @(posedge clk); #1;
    ui  = int'(d);
    si  = int'($signed(d));
    ev  = v;
    euh = v && ui > 255;
    esh = v && si > 127;
    esl = v && si < -128;
    if (v) begin
      eu_d = euh ? 8'd255 : 8'(ui);
      es_d = esh ? 8'd127 : esl ? 8'h80 : 8'(si);
    end
    if (STATS) begin
      eu_c = c ? 0 : (euh && eu_c < 65535) ? eu_c + 1 : eu_c;
      es_c = c ? 0 : ((esh || esl) && es_c < 65535) ? es_c + 1 : es_c;
    end
    if (ck) check_all(tag);
  endtask
  initial begin
    model_reset();
    #3 check_all("reset");
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; din = 10'h007;
    #1 chk("no zero latency", 32'(u_ov), 32'(0));
    step("pass 007", 1, 10'h007, 0, 1);
    step("u 0FF / s 0FF", 1, 10'h0FF, 0, 1);
    step("100", 1, 10'h100, 0, 1);
    step("3FF", 1, 10'h3FF, 0, 1);
    step("07F", 1, 10'h07F, 0, 1);
    step("080", 1, 10'h080, 0, 1);
    step("380", 1, 10'h380, 0, 1);
    step("37F", 1, 10'h37F, 0, 1);
    step("idle hold", 0, 10'h3FF, 0, 1);
    step("idle clr", 0, 10'h000, 1, 1);
    for (int i = 0; i < 300; i++) begin
      logic [9:0] d;
      d = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1) ? 10'h07E + 10'($urandom_range(0, 3)) :
                                              10'h37E + 10'($urandom_range(0, 3)))
                                      : 10'($urandom);
      step("random", $urandom_range(0, 3) != 0, d, $urandom_range(0, 15) == 0, 1);
    end
    step("burst a", 1, 10'h3FF, 0, 1);
    step("burst b", 1, 10'h042, 0, 1);
    in_valid = 1'b1; din = 10'h200;
    rst_n = 1'b0;
    model_reset();
    #1 check_all("mid reset");
    #2 rst_n = 1'b1;
    step("resume", 1, 10'h055, 0, 1);
    step("resume sat", 1, 10'h2AA, 0, 1);
    step("clr with sat", 1, 10'h1FF, 1, 1);
    step("sat 1", 1, 10'h300, 0, 1);
    step("sat 2", 1, 10'h0C0, 0, 1);
    step("sat 3", 1, 10'h3FF, 0, 1);
`ifdef SATURATE_U8_STATS_EN
    step("clr", 0, 10'h000, 1, 1);
    for (int i = 0; i < 3; i++) step("three sat", 1, 10'h300, 0, 1);
    chk("count three", 32'(u_cnt), 32'd3);
    step("clr priority", 1, 10'h300, 1, 1);
    chk("count clr", 32'(u_cnt), 32'd0);
    for (int i = 0; i < 70000; i++) step("ceiling", 1, 10'h300, 0, 0);
    check_all("ceiling");
    chk("count ceiling", 32'(u_cnt), 32'hFFFF);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
